serial_addsub: RTL and testbench

Parametrised bit-serial N-bit adder/subtractor. It uses a single full-adder/full-subtractor cell and processes one bit per clock, LSB first. A start/busy/done handshake controls each operation. It is the sequential, width-generic successor to the combinational half/full adder-subtractor cells, for area-constrained datapaths that can accept WIDTH-cycle latency.

---
 rtl/serial_addsub.sv | 272 +++++++++++++++++++++++++++
 tb/tb_serial_addsub.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial WIDTH-bit unsigned adder/subtractor. A single full-adder /
// full-subtractor cell is reused once per clock, LSB first, so one operation
// takes WIDTH clocks in RUN plus one DONE cycle (back-to-back starts accepted
// in DONE give one operation per WIDTH+1 cycles).
//
// Optional feature macro: OVERFLOW_FLAG_EN
//   When defined, adds output overflow_o: two's-complement signed overflow of
//   the completed operation, updated together with result_o.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset (aborts any operation)
//   start_i      request a new operation; honoured in IDLE and DONE only
//   mode_i       0 = add (a + b), 1 = subtract (a - b); sampled with start_i
//   a_i, b_i     unsigned operands, sampled with start_i
//   busy_o       high while an operation is in progress (RUN)
//   done_o       one-cycle pulse when result_o/carry_out_o are freshly valid
//   result_o     sum/difference modulo 2^WIDTH, held until next completion
//   carry_out_o  add: carry out of MSB; sub: borrow out of MSB (a < b)
//   overflow_o   (OVERFLOW_FLAG_EN only) signed overflow of the result
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
`ifdef OVERFLOW_FLAG_EN
    output logic             overflow_o,
`endif
    output logic             carry_out_o
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Operand shift registers: bit 0 always holds the bit being processed.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;

    // Partial result holds the WIDTH-1 low bits; the final (MSB) bit comes
    // straight from the cell on the completion edge, so no bit is ever dropped.
    logic [WIDTH-2:0] res_q, res_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    logic [1:0]       cell_s;
    logic             bit_s;
    logic             cy_nxt_s;
    logic             last_s;
    logic             run_s;
    logic             accept_s;
    logic             finish_s;
    logic [WIDTH-2:0] res_shift_s;

    // Full adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic ai, input logic bi, input logic ci);
        full_add = {(ai & bi) | (ai & ci) | (bi & ci), ai ^ bi ^ ci};
    endfunction

    // Full subtractor cell (ai - bi - wi): returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic wi);
        full_sub = {(~ai & bi) | (~(ai ^ bi) & wi), ai ^ bi ^ wi};
    endfunction

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded directly from the state flop.
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
            ST_RUN: begin
                busy_o = 1'b1;
                done_o = 1'b0;
            end
            ST_DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    // Shared arithmetic cell and control qualifiers.
    always_comb begin
        if (mode_q) begin
            cell_s = full_sub(a_q[0], b_q[0], cy_q);
        end else begin
            cell_s = full_add(a_q[0], b_q[0], cy_q);
        end
        bit_s    = cell_s[0];
        cy_nxt_s = cell_s[1];
        last_s   = (cnt_q == LAST_CNT);
        run_s    = (state_q == ST_RUN);
        accept_s = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        finish_s = run_s && last_s;
    end

    // Partial-result shift: new bit enters at the MSB side.
    if (WIDTH == 2) begin : g_res_narrow
        assign res_shift_s = bit_s;
    end else begin : g_res_wide
        assign res_shift_s = {bit_s, res_q[WIDTH-2:1]};
    end

    // Datapath next state: load on accept, shift one bit per RUN cycle.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        cy_d   = cy_q;
        res_d  = res_q;
        if (accept_s) begin
            a_d    = a_i;
            b_d    = b_i;
            mode_d = mode_i;
            cnt_d  = {CNT_W{1'b0}};
            cy_d   = 1'b0;
            res_d  = {(WIDTH-1){1'b0}};
        end else if (run_s) begin
            a_d    = {1'b0, a_q[WIDTH-1:1]};
            b_d    = {1'b0, b_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            cy_d   = cy_nxt_s;
            res_d  = res_shift_s;
        end else begin
            a_d    = a_q;
            b_d    = b_q;
            cnt_d  = cnt_q;
            cy_d   = cy_q;
            res_d  = res_q;
        end
    end

    // Output register next state: only the completion edge updates them.
    // On that edge a_q[0]/b_q[0] are the operand MSBs and bit_s is the result MSB.
    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d    = ovf_q;
`endif
        if (finish_s) begin
            result_d = {bit_s, res_q};
            carry_d  = cy_nxt_s;
`ifdef OVERFLOW_FLAG_EN
            if (mode_q) begin
                ovf_d = (a_q[0] != b_q[0]) && (bit_s != a_q[0]);
            end else begin
                ovf_d = (a_q[0] == b_q[0]) && (bit_s != a_q[0]);
            end
`endif
        end else begin
            result_d = result_q;
            carry_d  = carry_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= {WIDTH{1'b0}};
            b_q    <= {WIDTH{1'b0}};
            mode_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            cy_q   <= 1'b0;
            res_q  <= {(WIDTH-1){1'b0}};
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            cy_q   <= cy_d;
            res_q  <= res_d;
        end
    end

    // Result/flag output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign result_o    = result_q;
    assign carry_out_o = carry_q;
`ifdef OVERFLOW_FLAG_EN
    assign overflow_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//
// Self-checking bench for serial_addsub: an 8-bit and a 16-bit instance are
// driven with directed and $urandom operands and compared against a plain
// arithmetic reference model (modular sum/difference, unsigned compare for
// the borrow, signed range check for overflow).
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, mode8, busy8, done8, cy8;
    logic [7:0]  a8, b8, res8;
    logic        start16, mode16, busy16, done16, cy16;
    logic [15:0] a16, b16, res16;
`ifdef OVERFLOW_FLAG_EN
    logic        ov8, ov16;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start8),
        .mode_i      (mode8),
        .a_i         (a8),
        .b_i         (b8),
        .busy_o      (busy8),
        .done_o      (done8),
        .result_o    (res8),
`ifdef OVERFLOW_FLAG_EN
        .overflow_o  (ov8),
`endif
        .carry_out_o (cy8)
    );

    serial_addsub #(.WIDTH(16)) u_dut16 (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start16),
        .mode_i      (mode16),
        .a_i         (a16),
        .b_i         (b16),
        .busy_o      (busy16),
        .done_o      (done16),
        .result_o    (res16),
`ifdef OVERFLOW_FLAG_EN
        .overflow_o  (ov16),
`endif
        .carry_out_o (cy16)
    );

    // Reference model: w-bit modular add/sub, carry/borrow, signed overflow.
    function automatic void ref_op(input int w, input bit m,
                                   input longint unsigned x, input longint unsigned y,
                                   output longint unsigned r, output bit c, output bit v);
        longint unsigned modv;
        longint sx, sy, s, half;
        modv = 64'd1 << w;
        half = longint'(modv / 2);
        if (m == 1'b0) begin
            r = (x + y) % modv;
            c = (x + y) >= modv;
        end else begin
            r = (x + modv - y) % modv;
            c = x < y;
        end
        sx = (longint'(x) >= half) ? longint'(x) - longint'(modv) : longint'(x);
        sy = (longint'(y) >= half) ? longint'(y) - longint'(modv) : longint'(y);
        s  = m ? (sx - sy) : (sx + sy);
        v  = (s >= half) || (s < -half);
    endfunction

    // Issue one 8-bit operation; scramble inputs during RUN; wait for done.
    task automatic do_op8(input bit m, input logic [7:0] x, input logic [7:0] y,
                          output int busy_cnt, output bit got_done);
        int guard;
        @(negedge clk);
        start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (done8 !== 1'b1 && guard < 40) begin
            if (busy8 === 1'b1) busy_cnt++;
            mode8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
            guard++;
        end
        got_done = (done8 === 1'b1);
    endtask

    task automatic do_op16(input bit m, input logic [15:0] x, input logic [15:0] y,
                           output int busy_cnt, output bit got_done);
        int guard;
        @(negedge clk);
        start16 = 1'b1; mode16 = m; a16 = x; b16 = y;
        @(negedge clk);
        start16 = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (done16 !== 1'b1 && guard < 60) begin
            if (busy16 === 1'b1) busy_cnt++;
            mode16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
            @(negedge clk);
            guard++;
        end
        got_done = (done16 === 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy8, done8, res8, cy8} !== 11'd0) begin
            $display("FAIL reset8: busy=%b done=%b result=%h carry=%b, want all 0", busy8, done8, res8, cy8);
            n_fail++;
        end
        n_tests++;
        if ({busy16, done16, res16, cy16} !== 19'd0) begin
            $display("FAIL reset16: busy=%b done=%b result=%h carry=%b, want all 0", busy16, done16, res16, cy16);
            n_fail++;
        end
`ifdef OVERFLOW_FLAG_EN
        n_tests++;
        if ({ov8, ov16} !== 2'b00) begin
            $display("FAIL reset_ovf: got %b%b want 00", ov8, ov16);
            n_fail++;
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        bit          vm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0]  va [6] = '{8'h35, 8'hFF, 8'h7F, 8'h10, 8'h20, 8'h80};
        logic [7:0]  vb [6] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h20, 8'h01};
        longint unsigned r; bit c, v, got; int bc;
        for (int i = 0; i < 6; i++) begin
            do_op8(vm[i], va[i], vb[i], bc, got);
            ref_op(8, vm[i], 64'(va[i]), 64'(vb[i]), r, c, v);
            n_tests++;
            if (!got) begin $display("FAIL dir_done[%0d]: no done pulse within bound", i); n_fail++; end
            n_tests++;
            if (bc != 8) begin $display("FAIL dir_busy[%0d]: busy cycles %0d want 8", i, bc); n_fail++; end
            n_tests++;
            if (res8 !== r[7:0]) begin $display("FAIL dir_result[%0d]: got %h want %h", i, res8, r[7:0]); n_fail++; end
            n_tests++;
            if (cy8 !== c) begin $display("FAIL dir_carry[%0d]: got %b want %b", i, cy8, c); n_fail++; end
`ifdef OVERFLOW_FLAG_EN
            n_tests++;
            if (ov8 !== v) begin $display("FAIL dir_ovf[%0d]: got %b want %b", i, ov8, v); n_fail++; end
`endif
            @(negedge clk);
            n_tests++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                $display("FAIL dir_pulse[%0d]: done=%b busy=%b after pulse, want 0 0", i, done8, busy8);
                n_fail++;
            end
            n_tests++;
            if (res8 !== r[7:0]) begin $display("FAIL dir_hold[%0d]: got %h want %h", i, res8, r[7:0]); n_fail++; end
        end
    endtask

    task automatic test_random;
        logic [7:0] x, y; bit m, got; longint unsigned r; bit c, v; int bc;
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom);
            case ($urandom_range(0, 4))
                0: x = 8'h00;
                1: x = 8'hFF;
                2: x = 8'h80;
                default: x = 8'($urandom);
            endcase
            y = (i % 5 == 0) ? x : 8'($urandom);
            do_op8(m, x, y, bc, got);
            ref_op(8, m, 64'(x), 64'(y), r, c, v);
            n_tests++;
            if (!got || bc != 8 || res8 !== r[7:0] || cy8 !== c) begin
                $display("FAIL rand[%0d]: m=%b a=%h b=%h done=%b busy=%0d got %h/%b want %h/%b",
                         i, m, x, y, got, bc, res8, cy8, r[7:0], c);
                n_fail++;
            end
`ifdef OVERFLOW_FLAG_EN
            n_tests++;
            if (ov8 !== v) begin $display("FAIL rand_ovf[%0d]: got %b want %b", i, ov8, v); n_fail++; end
`endif
        end
    endtask

    task automatic test_start_during_run;
        longint unsigned r; bit c, v; int guard;
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; mode8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        guard = 0;
        while (done8 !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        ref_op(8, 1'b0, 64'h12, 64'h34, r, c, v);
        n_tests++;
        if (done8 !== 1'b1 || res8 !== r[7:0] || cy8 !== c) begin
            $display("FAIL run_start_ignored: done=%b got %h/%b want %h/%b", done8, res8, cy8, r[7:0], c);
            n_fail++;
        end
        @(negedge clk);
        n_tests++;
        if (busy8 !== 1'b0) begin $display("FAIL run_start_queued: busy=%b want 0", busy8); n_fail++; end
    endtask

    task automatic test_back_to_back;
        longint unsigned r; bit c, v; int t1, t2, guard;
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'h35; b8 = 8'h4A;
        @(negedge clk);
        mode8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
        guard = 0;
        while (done8 !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        t1 = cyc;
        ref_op(8, 1'b0, 64'h35, 64'h4A, r, c, v);
        n_tests++;
        if (done8 !== 1'b1 || res8 !== r[7:0] || cy8 !== c) begin
            $display("FAIL b2b_first: done=%b got %h/%b want %h/%b", done8, res8, cy8, r[7:0], c);
            n_fail++;
        end
        @(negedge clk);
        start8 = 1'b0;
        n_tests++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            $display("FAIL b2b_no_idle: busy=%b done=%b want 1 0", busy8, done8);
            n_fail++;
        end
        guard = 0;
        while (done8 !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        t2 = cyc;
        n_tests++;
        if (done8 !== 1'b1 || (t2 - t1) != 9) begin
            $display("FAIL b2b_spacing: done=%b spacing %0d want 9", done8, t2 - t1);
            n_fail++;
        end
        ref_op(8, 1'b1, 64'h10, 64'h20, r, c, v);
        n_tests++;
        if (res8 !== r[7:0] || cy8 !== c) begin
            $display("FAIL b2b_second: got %h/%b want %h/%b", res8, cy8, r[7:0], c);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        longint unsigned r; bit c, v, got, seen; int bc;
        do_op8(1'b0, 8'hF0, 8'h20, bc, got);
        n_tests++;
        if (!got || res8 !== 8'h10 || cy8 !== 1'b1) begin
            $display("FAIL pre_reset_op: done=%b got %h/%b want 10/1", got, res8, cy8);
            n_fail++;
        end
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'h01; b8 = 8'h02;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy8, done8, res8, cy8} !== 11'd0) begin
            $display("FAIL async_reset: busy=%b done=%b result=%h carry=%b, want all 0", busy8, done8, res8, cy8);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin $display("FAIL reset_abort: activity seen after reset, want none"); n_fail++; end
        do_op8(1'b1, 8'h5C, 8'hA3, bc, got);
        ref_op(8, 1'b1, 64'h5C, 64'hA3, r, c, v);
        n_tests++;
        if (!got || bc != 8 || res8 !== r[7:0] || cy8 !== c) begin
            $display("FAIL post_reset_op: done=%b busy=%0d got %h/%b want %h/%b", got, bc, res8, cy8, r[7:0], c);
            n_fail++;
        end
    endtask

    task automatic test_wide;
        logic [15:0] x, y; bit m, got, c, v; longint unsigned r; int bc;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                m = 1'b1; x = 16'h0001; y = 16'h0002;
            end else begin
                m = 1'($urandom); x = 16'($urandom); y = 16'($urandom);
            end
            do_op16(m, x, y, bc, got);
            ref_op(16, m, 64'(x), 64'(y), r, c, v);
            n_tests++;
            if (!got || bc != 16) begin
                $display("FAIL wide_timing[%0d]: done=%b busy cycles %0d want 16", i, got, bc);
                n_fail++;
            end
            n_tests++;
            if (res16 !== r[15:0] || cy16 !== c) begin
                $display("FAIL wide_result[%0d]: got %h/%b want %h/%b", i, res16, cy16, r[15:0], c);
                n_fail++;
            end
`ifdef OVERFLOW_FLAG_EN
            n_tests++;
            if (ov16 !== v) begin $display("FAIL wide_ovf[%0d]: got %b want %b", i, ov16, v); n_fail++; end
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; mode8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start16 = 1'b0; mode16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
        test_reset();
        test_directed();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
